// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: store-path writes land in a FIFO and are
// serialised LSB first onto txd, with back-to-back frames when data is queued.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [7:0]               wdata,
    output logic                     tx_ready,
    output logic                     txd,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    state_t        r_state, w_state_next;
    logic [BW-1:0] r_baud, w_baud_next;
    logic [2:0]    r_bit, w_bit_next;
    logic [7:0]    r_sh, w_sh_next;
    logic          r_txd, w_txd_next;

    logic w_push;
    logic w_pop;
    logic w_baud_end;
    logic w_not_empty;

    // Full is judged on occupancy alone, so a same-edge pop never frees a slot.
    assign tx_ready    = (r_count < FULL_COUNT);
    assign w_push      = we & tx_ready;
    assign w_not_empty = (r_count != '0);
    assign w_baud_end  = (r_baud == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (we && !tx_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_sh    <= w_sh_next;
            r_txd   <= w_txd_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_sh_next    = r_sh;
        w_txd_next   = r_txd;
        w_pop        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_txd_next = 1'b1;
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_sh_next    = r_mem[r_rd_ptr];
                    w_txd_next   = 1'b0;
                    w_baud_next  = '0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_txd_next   = r_sh[0];
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (r_bit == 3'd7) begin
                        w_txd_next   = 1'b1;
                        w_state_next = S_STOP;
                    end else begin
                        w_sh_next  = {1'b0, r_sh[7:1]};
                        w_txd_next = r_sh[1];
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (w_not_empty) begin
                        w_pop        = 1'b1;
                        w_sh_next    = r_mem[r_rd_ptr];
                        w_txd_next   = 1'b0;
                        w_state_next = S_START;
                    end else begin
                        w_txd_next   = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            default: begin
                w_txd_next   = 1'b1;
                w_baud_next  = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign txd      = r_txd;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign busy     = (r_state != S_IDLE) || w_not_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus bursty random writes, all
// compared cycle by cycle against a queue-and-timestamp model of the line.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we  = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [2:0] count;
    logic       overflow;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wdata   (wdata),
        .tx_ready(tx_ready),
        .txd     (txd),
        .busy    (busy),
        .count   (count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: queued bytes, plus the edge at which the byte on the line was popped.
    logic [7:0] q[$];
    bit         have_frame = 1'b0;
    int         pop_edge   = 0;
    logic [7:0] cur        = 8'h00;
    bit         ov         = 1'b0;
    int         n          = 0;
    int         frames     = 0;
    int         n_checks   = 0;
    int         n_errors   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit frame_active();
        return have_frame && ((n - pop_edge) < FRAME);
    endfunction

    function automatic logic exp_txd();
        int lvl;
        if (!frame_active()) return 1'b1;
        lvl = (n - pop_edge) / CPB;
        if (lvl == 0) return 1'b0;
        if (lvl <= 8) return cur[lvl-1];
        return 1'b1;
    endfunction

    task automatic check_outputs();
        check("txd",      {31'd0, txd},      {31'd0, exp_txd()});
        check("count",    {29'd0, count},    q.size());
        check("tx_ready", {31'd0, tx_ready}, {31'd0, q.size() < DEPTH});
        check("busy",     {31'd0, busy},     {31'd0, frame_active() || (q.size() != 0)});
        check("overflow", {31'd0, overflow}, {31'd0, ov});
    endtask

    task automatic step(input bit w, input logic [7:0] d);
        bit full;
        bit pop_now;
        we    = w;
        wdata = d;
        @(posedge clk);
        n++;
        full    = (q.size() >= DEPTH);
        pop_now = (q.size() > 0) && (!have_frame || (n - pop_edge) >= FRAME);
        if (w && full) ov = 1'b1;
        if (pop_now) begin
            cur        = q.pop_front();
            pop_edge   = n;
            have_frame = 1'b1;
            frames++;
            $display("frame %0d: byte 0x%02h starts after edge %0d", frames, cur, n);
        end
        if (w && !full) q.push_back(d);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 8'h00);
    endtask

    // Assert reset between edges, check at once, hold across edges, release mid-cycle.
    task automatic do_reset(input int hold);
        we = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        have_frame = 1'b0;
        ov         = 1'b0;
        check_outputs();
        repeat (hold) @(posedge clk);
        #1;
        check_outputs();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int rate;
        #1;
        do_reset(2);
        idle(3);

        // Single byte
        step(1'b1, 8'hA5);
        idle(FRAME + 5);

        // Back-to-back frames
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        idle(2 * FRAME + 5);

        // Fill to full and overflow
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
        idle(6 * FRAME);

        // Full FIFO with a write held across the STOP->START pop
        do_reset(1);
        for (int i = 0; i < FRAME + 10; i++) step(1'b1, 8'(8'h40 + i));
        idle(6 * FRAME);

        // Reset during data bit 3, long quiet line, then a clean frame
        step(1'b1, 8'h3C);
        idle(18);
        do_reset(1);
        idle(100);
        step(1'b1, 8'h81);
        idle(FRAME + 5);

        // Bursty random traffic with rare resets
        for (int blk = 0; blk < 64; blk++) begin
            case ($urandom_range(0, 3))
                0: rate = 0;
                1: rate = 25;
                2: rate = 60;
                default: rate = 100;
            endcase
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 1999) == 0) do_reset(1);
                step($urandom_range(0, 99) < rate, 8'($urandom_range(0, 255)));
            end
        end

        idle(DEPTH * FRAME + FRAME + 10);
        check("drained_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
